stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Parametrised multi-digit BCD stopwatch engine with start/stop, pause, lap (split-time freeze) and clear.
- Owns its own tick divider, button edge detection and mode FSM.
- Sits between the button synchroniser and the ssdec display decoders. Top level fans `bcd` nibbles out to ss0..ssN.

Parameters:
- DIGITS, 4, number of BCD decades (1..8); max count is 10^DIGITS-1 ticks.
- TICK_DIV, 10, clk cycles per count tick (100 Hz clock / 10 = 0.1 s resolution); must be >= 2.
- DIV_W, 7, divider counter width; requires 2^DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock (hz100 at top).
- rst  in  1  reset, synchronous, active-high.
- start_stop  in  1  synchronised button level; rising edge = press.
- lap  in  1  synchronised button level; rising edge = press.
- clr  in  1  synchronised button level; rising edge = press.
- bcd  out  4*DIGITS  displayed value; digit i at [4i+3:4i], digit 0 is least significant.
- state  out  2  current sw_state_t.
- lap_active  out  1  1 while the display is frozen (state LAP).
- tick  out  1  one-cycle pulse when the count increments.
- overflow  out  1  sticky; set when the count wraps from all-9s to 0.

Behaviour:
- Reset (rst=1 at a clk edge) sets state=IDLE, count=0, lap_reg=0, div=0 and overflow=0. The edge-detect history registers are set to 1, so a button held through reset release produces no press.
- Press detection: press = level & ~prev. prev is registered every cycle. The FSM acts at the same clk edge where the level is first sampled high, so there is 1 cycle of press-to-state latency.
- Priority for simultaneous presses: clr > start_stop > lap. Only one transition happens per cycle.
- IDLE: start_stop -> RUNNING. clr -> IDLE and re-zeroes everything. lap is ignored.
- RUNNING: start_stop -> PAUSED. lap -> LAP and captures lap_reg <= count (the pre-edge count). clr is ignored.
- LAP: lap -> RUNNING. start_stop -> PAUSED. clr is ignored. Counting continues in LAP.
- PAUSED: start_stop -> RUNNING. clr -> IDLE with count, div, lap_reg and overflow all zeroed. lap is ignored.
- Counting states are RUNNING and LAP only.
- Divider:
  - Increments by 1 each cycle while counting.
  - At TICK_DIV-1 it returns to 0, and that same cycle tick=1 (combinational).
  - Holds its value in PAUSED, so the fractional period is preserved across a pause.
- BCD counter:
  - On tick, digit 0 increments.
  - A digit at 9 with carry-in goes to 0 and carries out.
  - A digit never holds a value above 9.
  - The count updates at the edge ending the tick cycle.
- Wrap: all digits at 9 plus tick gives count=0 and overflow=1. Counting continues after a wrap. overflow stays set until clr->IDLE or rst.
- Display: bcd = lap_active ? lap_reg : count, combinational.
- Reset mid-operation: all state returns to the reset values at the next edge, regardless of button levels.

Decomposition:
- Package stopwatch_pkg holds:
  - typedef enum logic [1:0] sw_state_t: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10, LAP=2'b11.
  - localparam BCD_MAX=4'd9.
- Sub-module bcd_digit is one decade cell.
  - Inputs: clk, rst, clr, inc.
  - Outputs: digit[3:0], carry = inc & (digit==9).
  - Instantiated DIGITS times in a generate loop, with carry chained into the next inc.
- The divider and FSM stay inline in stopwatch_core.

Test Plan:
- Setup: DIGITS=4, TICK_DIV=10 unless noted. "Counting cycle" means a cycle spent in RUNNING or LAP.
1. rst, start_stop pulse, 250 counting cycles -> bcd=16'h0025, tick seen exactly 25 times at 10-cycle spacing, state=RUNNING.
2. Start, 15 counting cycles (bcd=0001, div=5), start_stop, wait 100 cycles -> bcd stays 0001, no tick. start_stop, 5 counting cycles -> bcd=0002.
3. Run to bcd=0042, lap press -> lap_active=1, bcd frozen at 0042. 300 more cycles -> bcd still 0042. lap press -> bcd=0072, state=RUNNING.
4. DIGITS=2, run 1000 counting cycles -> tick 100 produces bcd=00 and overflow=1. clr during RUNNING -> ignored. start_stop then clr -> IDLE, bcd=00, overflow=0.
5. In PAUSED, clr and start_stop rise in the same cycle -> IDLE (clr wins).
6. Hold start_stop high across rst deassertion -> state stays IDLE. rst pulse while RUNNING at bcd=0013 -> next cycle bcd=0000, state=IDLE, tick=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch engine.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    LAP     = 2'b11
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD decade: counts 0..9 on inc, carries out when wrapping from 9.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      digit <= '0;
    else if (inc)
      digit <= (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
  end

  assign carry = inc & (digit == BCD_MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch engine: button edges, mode FSM, tick divider and BCD chain.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10,
  parameter int DIV_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_stop,
  input  logic                lap,
  input  logic                clr,
  output logic [4*DIGITS-1:0] bcd,
  output logic [1:0]          state,
  output logic                lap_active,
  output logic                tick,
  output logic                overflow
);

  sw_state_t           st;
  logic [DIV_W-1:0]    div;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] lap_reg;
  logic [DIGITS:0]     chain;
  logic                prev_ss;
  logic                prev_lap;
  logic                prev_clr;
  logic                ss_p;
  logic                lap_p;
  logic                clr_p;
  logic                counting;
  logic                wipe;

  // History starts high so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ss  <= 1'b1;
      prev_lap <= 1'b1;
      prev_clr <= 1'b1;
    end else begin
      prev_ss  <= start_stop;
      prev_lap <= lap;
      prev_clr <= clr;
    end
  end

  assign ss_p  = start_stop & ~prev_ss;
  assign lap_p = lap & ~prev_lap;
  assign clr_p = clr & ~prev_clr;

  assign counting = (st == RUNNING) || (st == LAP);
  assign tick     = counting && (div == DIV_W'(TICK_DIV - 1));
  assign wipe     = clr_p && ((st == IDLE) || (st == PAUSED));

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      div      <= '0;
      lap_reg  <= '0;
      overflow <= 1'b0;
    end else if (wipe) begin
      st       <= IDLE;
      div      <= '0;
      lap_reg  <= '0;
      overflow <= 1'b0;
    end else begin
      if (counting)
        div <= tick ? '0 : div + DIV_W'(1);
      if (chain[DIGITS])
        overflow <= 1'b1;
      case (st)
        IDLE: begin
          if (ss_p)
            st <= RUNNING;
        end
        RUNNING: begin
          if (ss_p) begin
            st <= PAUSED;
          end else if (lap_p) begin
            st      <= LAP;
            lap_reg <= count;
          end
        end
        LAP: begin
          if (ss_p)
            st <= PAUSED;
          else if (lap_p)
            st <= RUNNING;
        end
        PAUSED: begin
          if (ss_p)
            st <= RUNNING;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign chain[0] = tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk   (clk),
      .rst   (rst),
      .clr   (wipe),
      .inc   (chain[i]),
      .digit (count[4*i +: 4]),
      .carry (chain[i+1])
    );
  end

  assign state      = st;
  assign lap_active = (st == LAP);
  assign bcd        = lap_active ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench: vector table plus tick scoreboard and corner sequences.
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clr = 1'b0;

  logic [15:0] bcd4;
  logic [1:0]  state4;
  logic        lap_active4;
  logic        tick4;
  logic        overflow4;

  logic [7:0]  bcd2;
  logic [1:0]  state2;
  logic        lap_active2;
  logic        tick2;
  logic        overflow2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ticks = 0;
  bit mon_en = 1'b0;
  int exp_q[$];

  always #5 clk = ~clk;

  stopwatch_core u4 (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .lap        (lap),
    .clr        (clr),
    .bcd        (bcd4),
    .state      (state4),
    .lap_active (lap_active4),
    .tick       (tick4),
    .overflow   (overflow4)
  );

  stopwatch_core #(.DIGITS(2)) u2 (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .lap        (lap),
    .clr        (clr),
    .bcd        (bcd2),
    .state      (state2),
    .lap_active (lap_active2),
    .tick       (tick2),
    .overflow   (overflow2)
  );

  // Scoreboard: cycle index of each tick, taken at the edge ending it.
  always @(posedge clk) begin
    int e;
    if (mon_en && tick4) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tick_extra cyc=%0d want no tick", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL tick_time got=%0d want=%0d", cyc, e);
        end
      end
    end
    if (tick4)
      ticks++;
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    start_stop = s;
    lap = l;
    clr = c;
    @(negedge clk);
    start_stop = 1'b0;
    lap = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        ss;
    logic        lp;
    logic        cl;
    int          n;
    logic [1:0]  st;
    logic [15:0] bcd;
    logic        la;
    int          tk;
  } vec_t;

  vec_t vt[17];

  initial begin
    int c0;
    int t0;

    vt[0]  = '{1'b1, 1'b0, 1'b0,  14, 2'd1, 16'h0001, 1'b0,  1};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 100, 2'd2, 16'h0001, 1'b0,  0};
    vt[2]  = '{1'b1, 1'b0, 1'b0,   5, 2'd1, 16'h0002, 1'b0,  1};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 399, 2'd1, 16'h0042, 1'b0, 40};
    vt[4]  = '{1'b0, 1'b1, 1'b0,   0, 2'd3, 16'h0042, 1'b1,  0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 299, 2'd3, 16'h0042, 1'b1, 30};
    vt[6]  = '{1'b0, 1'b1, 1'b0,   0, 2'd1, 16'h0072, 1'b0,  0};
    vt[7]  = '{1'b1, 1'b0, 1'b0,   0, 2'd2, 16'h0072, 1'b0,  0};
    vt[8]  = '{1'b1, 1'b0, 1'b1,   0, 2'd0, 16'h0000, 1'b0,  0};
    vt[9]  = '{1'b0, 1'b1, 1'b0,   3, 2'd0, 16'h0000, 1'b0,  0};
    vt[10] = '{1'b1, 1'b0, 1'b0,   9, 2'd1, 16'h0000, 1'b0,  0};
    vt[11] = '{1'b0, 1'b0, 1'b1,   0, 2'd1, 16'h0001, 1'b0,  1};
    vt[12] = '{1'b1, 1'b1, 1'b0,   0, 2'd2, 16'h0001, 1'b0,  0};
    vt[13] = '{1'b0, 1'b1, 1'b0,   0, 2'd2, 16'h0001, 1'b0,  0};
    vt[14] = '{1'b1, 1'b0, 1'b0,   0, 2'd1, 16'h0001, 1'b0,  0};
    vt[15] = '{1'b0, 1'b1, 1'b0,   0, 2'd3, 16'h0001, 1'b1,  0};
    vt[16] = '{1'b1, 1'b0, 1'b0,   0, 2'd2, 16'h0001, 1'b0,  0};

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_state", 32'(state4), 32'd0);
    chk("rst_bcd", 32'(bcd4), 32'h0);
    chk("rst_ovf", 32'(overflow4), 32'd0);
    chk("rst_lap", 32'(lap_active4), 32'd0);
    chk("rst_tick", 32'(tick4), 32'd0);
    @(negedge clk);

    // Free run: 25 ticks, every 10 cycles
    c0 = cyc;
    for (int j = 0; j < 25; j++)
      exp_q.push_back(c0 + 10 + 10 * j);
    mon_en = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    repeat (250) @(negedge clk);
    mon_en = 1'b0;
    chk("run_bcd", 32'(bcd4), 32'h0025);
    chk("run_state", 32'(state4), 32'd1);
    chk("run_ticks_left", 32'(exp_q.size()), 32'd0);

    // Vector table
    do_reset();
    for (int i = 0; i < 17; i++) begin
      t0 = ticks;
      press(vt[i].ss, vt[i].lp, vt[i].cl);
      repeat (vt[i].n) @(negedge clk);
      chk($sformatf("v%0d_state", i), 32'(state4), 32'(vt[i].st));
      chk($sformatf("v%0d_bcd", i), 32'(bcd4), 32'(vt[i].bcd));
      chk($sformatf("v%0d_lap", i), 32'(lap_active4), 32'(vt[i].la));
      chk($sformatf("v%0d_ovf", i), 32'(overflow4), 32'd0);
      chk($sformatf("v%0d_ticks", i), 32'(ticks - t0), 32'(vt[i].tk));
    end

    // Two-digit wrap and sticky overflow
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    repeat (999) @(negedge clk);
    chk("wrap_pre_bcd", 32'(bcd2), 32'h99);
    chk("wrap_pre_ovf", 32'(overflow2), 32'd0);
    chk("wrap_pre_tick", 32'(tick2), 32'd1);
    @(negedge clk);
    chk("wrap_bcd", 32'(bcd2), 32'h00);
    chk("wrap_ovf", 32'(overflow2), 32'd1);
    chk("wrap_state", 32'(state2), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    chk("wrap_clr_ign_state", 32'(state2), 32'd1);
    chk("wrap_clr_ign_ovf", 32'(overflow2), 32'd1);
    press(1'b1, 1'b0, 1'b0);
    chk("wrap_pause", 32'(state2), 32'd2);
    press(1'b0, 1'b0, 1'b1);
    chk("wrap_clr_state", 32'(state2), 32'd0);
    chk("wrap_clr_bcd", 32'(bcd2), 32'h00);
    chk("wrap_clr_ovf", 32'(overflow2), 32'd0);

    // Button held across reset release, then reset mid-run
    rst = 1'b1;
    start_stop = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_state", 32'(state4), 32'd0);
    start_stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_rel_state", 32'(state4), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    repeat (130) @(negedge clk);
    chk("mid_bcd", 32'(bcd4), 32'h0013);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_bcd", 32'(bcd4), 32'h0000);
    chk("mid_rst_state", 32'(state4), 32'd0);
    chk("mid_rst_tick", 32'(tick4), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
